// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder sequenced LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module fulladder_structural (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic p;
    logic g;
    logic pc;

    xor x0 (p, a, b);
    xor x1 (sum, p, cin);
    and a0 (g, a, b);
    and a1 (pc, p, cin);
    or  o0 (cout, g, pc);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             last;
    logic             fa_sum;
    logic             fa_cout;

    fulladder_structural u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        sum_nxt          = sum_sh >> 1;
        sum_nxt[WIDTH-1] = fa_sum;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                a_sh   <= a;
                b_sh   <= b;
                sum_sh <= '0;
                carry  <= cin;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                sum_sh <= sum_nxt;
                carry  <= fa_cout;
                cnt    <= cnt + CW'(1);
                // the MSB bit is being added now: latch the final results
                if (last) begin
                    sum  <= sum_nxt;
                    cout <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                    ovf  <= carry ^ fa_cout;
`endif
                end
            end
        end
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. Sequences one instance of the team's fulladder_structural cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. It owns the operand shift registers, the carry flop, the bit counter and the start/busy/done handshake. Used where area matters more than latency, e.g. accumulator updates in slow control paths.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  request; sampled only when busy=0
a  input  WIDTH  operand A, captured on the accepted-start edge
b  input  WIDTH  operand B, captured on the accepted-start edge
cin  input  1  carry-in, captured on the accepted-start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result; stable from done until the next accepted start
cout  output  1  final carry-out; same validity as sum

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: rst_n=0 at a rising edge sets state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0 and cnt=0, and clears both shift registers. Reset overrides start.
- FSM states: IDLE, RUN, DONE. busy is registered and equals (state==RUN). done is registered and equals (state==DONE).
- IDLE: start=1 at an edge loads a_sh=a, b_sh=b, carry=cin and cnt=0, then moves to RUN. start=0 stays in IDLE.
- RUN, each edge:
  - Full adder inputs are a_sh[0], b_sh[0] and carry.
  - The fa sum bit is shifted into sum_sh MSB (sum_sh >> 1).
  - a_sh and b_sh shift right by 1. carry takes the fa cout. cnt increments.
  - When cnt==WIDTH-1 on this edge, the state moves to DONE, sum takes the final sum_sh and cout takes the final carry.
- Latency: done is high in the cycle beginning exactly WIDTH edges after the accepted-start edge. Example: WIDTH=8, start accepted at edge 0, done high between edges 8 and 9.
- DONE: lasts one cycle. start=1 is accepted exactly as in IDLE, giving back-to-back operation and a 1-cycle gap. Otherwise the state moves to IDLE.
- start while busy=1 is ignored. No queuing, and operands are not re-sampled.
- Operand inputs are don't-care except on the accepted-start edge.
- sum and cout hold their value through IDLE. They change only on the DONE-entry edge and on reset.
- WIDTH=1: RUN lasts one edge. done follows start by 1 cycle.
- cnt width is $clog2(WIDTH+1). cnt never wraps within one operation.
- Reset mid-RUN aborts the operation. done is not asserted for the aborted operation, and sum/cout read 0.
- Combinational path from start to busy or done: none.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit) for two's-complement signed overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured with the MSB bit in RUN.
  - ovf is registered and updated with sum/cout on DONE entry. Reset value is 0, and it holds like sum.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8, a=8'h5A, b=8'h33, cin=0, start pulsed 1 cycle -> busy high for 8 cycles, done pulse 8 cycles after the start edge, sum=8'h8D, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 issued in the DONE cycle -> accepted back-to-back, sum=8'hFF, cout=1.
3. Start 5A+33 and hold start=1 with a=8'h01, b=8'h01 through RUN -> the second request is ignored until DONE. The first result is 8'h8D. The second op, accepted in DONE, gives 8'h02.
4. Start an op, drive rst_n=0 at RUN cycle 4 -> next edge busy=0, done=0, sum=0. The done pulse never appears. A subsequent op 8'h10+8'h20 completes with 8'h30.
5. WIDTH=1 build: a=1, b=1, cin=1 -> done 1 cycle after start, sum=1, cout=1.
6. With SERIAL_ADD_OVF_EN defined:
   - 8'h7F+8'h01 -> sum=8'h80, cout=0, ovf=1.
   - 8'h80+8'h80 -> sum=8'h00, cout=1, ovf=1.
   - 8'h5A+8'h33 -> ovf=1.
   - 8'h10+8'h20 -> ovf=0.
